// File: rtl/nes_button_events_pkg.sv
// Shared types for the NES button event path: button indices and the queued event format.
package nes_pkg;
   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   typedef struct packed {
      logic       press;
      logic [2:0] idx;
   } nes_event_t;

   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      lowest_set = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (v[i]) lowest_set = 3'(i);
   endfunction
endpackage

// File: rtl/nes_button_events_fifo.sv
// Small synchronous FIFO with a registered head word; a full FIFO accepts a push only alongside a pop.
module event_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
   logic [AW:0]      count, count_next;
   logic             do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_next = rd_ptr + AW'(do_pop);
   assign count_next = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};

   always_ff @(posedge CLK)
      if (do_push) mem[wr_ptr] <= din;

   // The head is fetched one cycle early so ev_code leaves a flop; a word
   // written this cycle into the slot that becomes head is forwarded directly.
   always_ff @(posedge CLK) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr <= rd_next;
         count  <= count_next;
         if (count_next != '0)
            head <= (do_push && rd_next == wr_ptr) ? din : mem[rd_next];
      end
   end
endmodule

// File: rtl/nes_button_events.sv
// Debounces the 8-bit NES frame into a held vector and queues press/release events for game logic.
module nes_button_events
   import nes_pkg::*;
#(
   parameter int STABLE_N   = 3,
   parameter int CNT_W      = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       en,
   input  logic       sample_valid,
   input  logic [7:0] buttons_n,
   input  logic       ev_ready,
   input  logic       clr_overflow,
   output logic [7:0] held,
   output logic       ev_valid,
   output logic [3:0] ev_code,
   output logic       overflow
);
   logic [CNT_W-1:0] cnt [8];
   logic [7:0]       pending, ptype, raw, accept, push_mask;
   logic             sample, pop, push, fifo_full, fifo_empty, collide;
   logic [2:0]       sel;
   nes_event_t       ev_in;

   assign raw       = ~buttons_n;
   assign sample    = sample_valid & en;
   assign pop       = ev_valid & ev_ready;
   assign sel       = lowest_set(pending);
   assign push      = (|pending) & (~fifo_full | pop);
   assign push_mask = push ? (8'b1 << sel) : 8'b0;
   assign ev_in.press = ptype[sel];
   assign ev_in.idx   = sel;
   assign ev_valid  = ~fifo_empty;

   always_comb begin
      accept = '0;
      for (int i = 0; i < 8; i++)
         accept[i] = sample && (raw[i] != held[i]) &&
                     (({1'b0, cnt[i]} + (CNT_W+1)'(1)) == (CNT_W+1)'(STABLE_N));
   end

   // An event pushed this very cycle is not lost, so only a still-waiting one collides.
   assign collide = |(accept & pending & ~push_mask);

   always_ff @(posedge CLK) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) cnt[i] <= '0;
         held     <= '0;
         pending  <= '0;
         ptype    <= '0;
         overflow <= 1'b0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (sample) begin
               if (raw[i] == held[i] || accept[i]) cnt[i] <= '0;
               else                                cnt[i] <= cnt[i] + CNT_W'(1);
               if (accept[i]) begin
                  held[i]  <= raw[i];
                  ptype[i] <= raw[i];
               end
            end
         end
         pending <= (pending & ~push_mask) | accept;
         if (collide)           overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

   event_fifo #(.WIDTH(4), .DEPTH(FIFO_DEPTH)) u_fifo (
      .CLK   (CLK),
      .reset (reset),
      .push  (push),
      .din   (ev_in),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (ev_code)
   );
endmodule

// File: tb/tb_nes_button_events.sv
// Directed scenarios plus randomized traffic, checked against a queue-based reference model.
module tb_nes_button_events;
   localparam int N     = 3;
   localparam int DEPTH = 4;

   logic       CLK = 1'b0;
   logic       reset = 1'b1, en = 1'b1, sample_valid = 1'b0, ev_ready = 1'b0, clr_overflow = 1'b0;
   logic [7:0] buttons_n = 8'hFF;
   logic [7:0] held;
   logic       ev_valid, overflow;
   logic [3:0] ev_code;

   int n_tests = 0, n_fail = 0;
   bit mon_on = 0;

   // reference model state
   logic [7:0] m_held = '0, m_pend = '0, m_ptype = '0;
   int         m_dcnt [8];
   bit         m_ovf = 0;
   int         m_fcnt = 0;
   logic [3:0] sb [$];

   nes_button_events dut (
      .CLK(CLK), .reset(reset), .en(en), .sample_valid(sample_valid),
      .buttons_n(buttons_n), .ev_ready(ev_ready), .clr_overflow(clr_overflow),
      .held(held), .ev_valid(ev_valid), .ev_code(ev_code), .overflow(overflow));

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit pop, pushing, coll;
      int sel;
      logic r;
      if (reset) begin
         m_held = '0; m_pend = '0; m_ptype = '0; m_ovf = 0; m_fcnt = 0;
         for (int i = 0; i < 8; i++) m_dcnt[i] = 0;
         sb.delete();
         return;
      end
      pop = ev_ready && m_fcnt > 0;
      sel = -1;
      for (int i = 0; i < 8; i++) if (m_pend[i] && sel < 0) sel = i;
      pushing = (sel >= 0) && (m_fcnt < DEPTH || pop);
      if (pushing) begin
         sb.push_back({m_ptype[sel], 3'(sel)});
         m_pend[sel] = 1'b0;
      end
      coll = 0;
      if (sample_valid && en) begin
         for (int i = 0; i < 8; i++) begin
            r = ~buttons_n[i];
            if (r == m_held[i]) m_dcnt[i] = 0;
            else if (m_dcnt[i] + 1 < N) m_dcnt[i]++;
            else begin
               m_held[i] = r;
               m_dcnt[i] = 0;
               if (m_pend[i]) coll = 1;
               m_pend[i]  = 1'b1;
               m_ptype[i] = r;
            end
         end
      end
      if (coll) m_ovf = 1;
      else if (clr_overflow) m_ovf = 0;
      m_fcnt = m_fcnt + int'(pushing) - int'(pop);
   endtask

   task automatic monitor_step();
      if (!mon_on || reset) return;
      check("held", held, m_held);
      check("overflow", overflow, m_ovf);
      check("ev_valid", ev_valid, m_fcnt > 0);
      if (ev_valid && ev_ready) begin
         if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL ev_pop: got code %0h expected no event", ev_code);
         end else check("ev_code", ev_code, sb.pop_front());
      end
   endtask

   always @(posedge CLK) model_step();
   always @(negedge CLK) monitor_step();

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   task automatic strobe(input logic [7:0] bn);
      sample_valid = 1'b1; buttons_n = bn;
      tick();
      sample_valid = 1'b0;
      tick();
   endtask

   initial begin
      logic [7:0] base;
      for (int i = 0; i < 8; i++) m_dcnt[i] = 0;
      tick(2);
      reset = 1'b0;
      tick();
      mon_on = 1;
      check("rst_held", held, 8'h00);
      check("rst_valid", ev_valid, 1'b0);
      check("rst_code", ev_code, 4'h0);
      check("rst_ovf", overflow, 1'b0);

      // 1: press A
      repeat (3) strobe(8'hFE);
      check("t1_held", held, 8'h01);
      check("t1_valid", ev_valid, 1'b1);
      check("t1_code", ev_code, 4'b1000);
      ev_ready = 1'b1;
      repeat (3) strobe(8'hFF);
      tick(3);

      // 2: glitch restarts agreement count
      strobe(8'hFE); strobe(8'hFF); strobe(8'hFE); strobe(8'hFE);
      check("t2_hold_off", held, 8'h00);
      strobe(8'hFE);
      check("t2_held", held, 8'h01);
      repeat (3) strobe(8'hFF);
      tick(3);

      // 3: all buttons, consumer stalled
      ev_ready = 1'b0;
      repeat (3) strobe(8'h00);
      tick(6);
      check("t3_held", held, 8'hFF);
      check("t3_valid", ev_valid, 1'b1);
      check("t3_code", ev_code, 4'b1000);
      check("t3_ovf", overflow, 1'b0);
      ev_ready = 1'b1;
      tick(12);
      check("t3_drained", ev_valid, 1'b0);

      // 4: collision on A while FIFO full
      ev_ready = 1'b0;
      repeat (3) strobe(8'hFF);
      repeat (3) strobe(8'hFE);
      repeat (3) strobe(8'hFF);
      check("t4_ovf", overflow, 1'b1);
      clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
      check("t4_clr", overflow, 1'b0);
      ev_ready = 1'b1;
      tick(16);

      // 5: en low freezes debounce, FIFO still drains
      ev_ready = 1'b0;
      repeat (3) strobe(8'h7F);
      en = 1'b0; ev_ready = 1'b1;
      repeat (3) strobe(8'h00);
      check("t5_held", held, 8'h80);
      check("t5_drained", ev_valid, 1'b0);
      en = 1'b1;

      // 6: reset with events queued
      ev_ready = 1'b0;
      repeat (3) strobe(8'h7C);
      tick(2);
      check("t6_queued", ev_valid, 1'b1);
      reset = 1'b1; tick();
      check("t6_valid", ev_valid, 1'b0);
      check("t6_held", held, 8'h00);
      reset = 1'b0; ev_ready = 1'b1;
      tick(4);
      check("t6_stale", ev_valid, 1'b0);

      // randomized traffic
      base = 8'hFF;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 5) == 0) base[$urandom_range(0, 7)] ^= 1'b1;
         buttons_n    = base;
         if ($urandom_range(0, 7) == 0) buttons_n[$urandom_range(0, 7)] ^= 1'b1;
         sample_valid = $urandom_range(0, 1);
         en           = ($urandom_range(0, 7) != 0);
         ev_ready     = ($urandom_range(0, 3) == 0);
         clr_overflow = ($urandom_range(0, 15) == 0);
         reset        = ($urandom_range(0, 399) == 0);
         tick();
      end
      reset = 1'b0; sample_valid = 1'b0; clr_overflow = 1'b0; ev_ready = 1'b1; en = 1'b1;
      tick(20);
      check("final_drained", ev_valid, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
